// File: rtl/maindec_aludec_alu_pkg.sv
// Shared opcode, ALU control and aluop-class constants for the decode/execute core.
package maindec_aludec_alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_SUBU = 6'b100011;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_NOR  = 6'b100111;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_SLTU = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       memwrite;
    logic       memtoreg;
    logic       jump;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/maindec_aludec_alu_alu.sv
// 32-bit ALU with zero and signed-overflow flags; unknown codes yield 0.
module maindec_aludec_alu_alu
  import maindec_aludec_alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [5:0]  i_alucontrol,
  output logic [31:0] o_result,
  output logic        o_zero,
  output logic        o_overflow
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_slt;
  logic        w_sltu;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_slt  = $signed(i_a) < $signed(i_b);
  assign w_sltu = i_a < i_b;

  always_comb begin
    o_result   = '0;
    o_overflow = 1'b0;
    case (i_alucontrol)
      ALU_ADD: begin
        o_result   = w_sum;
        o_overflow = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
      end
      ALU_ADDU: o_result = w_sum;
      ALU_SUB: begin
        o_result   = w_diff;
        o_overflow = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
      end
      ALU_SUBU: o_result = w_diff;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_NOR:  o_result = ~(i_a | i_b);
      ALU_SLT:  o_result = {31'b0, w_slt};
      ALU_SLTU: o_result = {31'b0, w_sltu};
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == 32'b0);

endmodule

// File: rtl/maindec_aludec_alu_aludec.sv
// ALU decoder: aluop class plus funct to 6-bit ALU control.
module maindec_aludec_alu_aludec
  import maindec_aludec_alu_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [5:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD:   o_alucontrol = ALU_ADD;
      ALUOP_SUB:   o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: o_alucontrol = i_funct;
      default:     o_alucontrol = ALU_OR;
    endcase
  end

endmodule

// File: rtl/maindec_aludec_alu_maindec.sv
// Main decoder: opcode to control bundle. Define ORI_EN to decode ori.
module maindec_aludec_alu_maindec
  import maindec_aludec_alu_pkg::*;
(
  input  logic [5:0] i_op,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  // Literal order: regwrite regdst alusrc branch memwrite memtoreg jump, then aluop.
  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_RTYPE: o_ctrl = {7'b1100000, ALUOP_FUNCT};
      OP_LW:    o_ctrl = {7'b1010010, ALUOP_ADD};
      OP_SW:    o_ctrl = {7'b0010100, ALUOP_ADD};
      OP_BEQ:   o_ctrl = {7'b0001000, ALUOP_SUB};
      OP_ADDI:  o_ctrl = {7'b1010000, ALUOP_ADD};
      OP_J:     o_ctrl = {7'b0000001, ALUOP_ADD};
`ifdef ORI_EN
      OP_ORI:   o_ctrl = {7'b1010000, ALUOP_OR};
`endif
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/maindec_aludec_alu.sv
// Decode/execute core top: main decoder, ALU decoder, ALU and sticky overflow flag.
// Define ORI_EN to enable ori decoding in the main decoder.
module maindec_aludec_alu
  import maindec_aludec_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output logic        memtoreg,
  output logic        memwrite,
  output logic        branch,
  output logic        alusrc,
  output logic        regdst,
  output logic        regwrite,
  output logic        jump,
  output logic [1:0]  aluop,
  output logic        illegal,
  input  logic [1:0]  aluop_in,
  output logic [5:0]  alucontrol,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  alucontrol_in,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  input  logic        stat_clr,
  output logic        ovf_sticky
);

  ctrl_t w_ctrl;
  logic  r_ovf_sticky;

  maindec_aludec_alu_maindec u_maindec (
    .i_op      (op),
    .o_ctrl    (w_ctrl),
    .o_illegal (illegal)
  );

  assign regwrite = w_ctrl.regwrite;
  assign regdst   = w_ctrl.regdst;
  assign alusrc   = w_ctrl.alusrc;
  assign branch   = w_ctrl.branch;
  assign memwrite = w_ctrl.memwrite;
  assign memtoreg = w_ctrl.memtoreg;
  assign jump     = w_ctrl.jump;
  assign aluop    = w_ctrl.aluop;

  maindec_aludec_alu_aludec u_aludec (
    .i_aluop      (aluop_in),
    .i_funct      (funct),
    .o_alucontrol (alucontrol)
  );

  maindec_aludec_alu_alu u_alu (
    .i_a          (a),
    .i_b          (b),
    .i_alucontrol (alucontrol_in),
    .o_result     (result),
    .o_zero       (zero),
    .o_overflow   (overflow)
  );

  // Clear takes priority over a same-cycle overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_sticky <= 1'b0;
    end else if (stat_clr) begin
      r_ovf_sticky <= 1'b0;
    end else if (overflow) begin
      r_ovf_sticky <= 1'b1;
    end
  end

  assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_maindec_aludec_alu.sv
// Randomized self-checking bench for maindec_aludec_alu against a behavioural model.
module tb_maindec_aludec_alu;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump;
  logic [1:0]  aluop;
  logic        illegal;
  logic [1:0]  aluop_in;
  logic [5:0]  alucontrol;
  logic [31:0] a, b;
  logic [5:0]  alucontrol_in;
  logic [31:0] result;
  logic        zero, overflow;
  logic        stat_clr;
  logic        ovf_sticky;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          model_sticky;

  maindec_aludec_alu dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct         (funct),
    .memtoreg      (memtoreg),
    .memwrite      (memwrite),
    .branch        (branch),
    .alusrc        (alusrc),
    .regdst        (regdst),
    .regwrite      (regwrite),
    .jump          (jump),
    .aluop         (aluop),
    .illegal       (illegal),
    .aluop_in      (aluop_in),
    .alucontrol    (alucontrol),
    .a             (a),
    .b             (b),
    .alucontrol_in (alucontrol_in),
    .result        (result),
    .zero          (zero),
    .overflow      (overflow),
    .stat_clr      (stat_clr),
    .ovf_sticky    (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // {illegal, regwrite regdst alusrc branch memwrite memtoreg jump, aluop}
  function automatic logic [9:0] ref_dec(input logic [5:0] o);
    case (o)
      6'b000000: return {1'b0, 7'b1100000, 2'b10};
      6'b100011: return {1'b0, 7'b1010010, 2'b00};
      6'b101011: return {1'b0, 7'b0010100, 2'b00};
      6'b000100: return {1'b0, 7'b0001000, 2'b01};
      6'b001000: return {1'b0, 7'b1010000, 2'b00};
      6'b000010: return {1'b0, 7'b0000001, 2'b00};
`ifdef ORI_EN
      6'b001101: return {1'b0, 7'b1010000, 2'b11};
`endif
      default:   return {1'b1, 9'b0};
    endcase
  endfunction

  function automatic logic [5:0] ref_aludec(input logic [1:0] c, input logic [5:0] f);
    case (c)
      2'b00:   return 6'h20;
      2'b01:   return 6'h22;
      2'b10:   return f;
      default: return 6'h25;
    endcase
  endfunction

  // Overflow judged by exact signed arithmetic in 64 bits, not by sign-bit rules.
  task automatic ref_alu(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output logic ovf);
    longint sx, sy, s;
    longint ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    ovf = 1'b0;
    case (c)
      6'h20, 6'h21: begin
        s = sx + sy;
        res = s[31:0];
        if (c == 6'h20) ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'h22, 6'h23: begin
        s = sx - sy;
        res = s[31:0];
        if (c == 6'h22) ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'h24:   res = x & y;
      6'h25:   res = x | y;
      6'h26:   res = x ^ y;
      6'h27:   res = ~(x | y);
      6'h2A:   res = (sx < sy) ? 32'd1 : 32'd0;
      6'h2B:   res = (ux < uy) ? 32'd1 : 32'd0;
      default: res = 32'd0;
    endcase
  endtask

  task automatic apply(input logic [5:0] o, input logic [5:0] f, input logic [1:0] ai,
                       input logic [5:0] ci, input logic [31:0] x, input logic [31:0] y,
                       input logic clr);
    logic [31:0] exp_res;
    logic        exp_ovf;
    @(negedge clk);
    op = o; funct = f; aluop_in = ai; alucontrol_in = ci; a = x; b = y; stat_clr = clr;
    #1;
    ref_alu(ci, x, y, exp_res, exp_ovf);
    check("decode", {22'b0, illegal, regwrite, regdst, alusrc, branch, memwrite, memtoreg,
                     jump, aluop}, {22'b0, ref_dec(o)});
    check("alucontrol", {26'b0, alucontrol}, {26'b0, ref_aludec(ai, f)});
    check("result", result, exp_res);
    check("zero", {31'b0, zero}, {31'b0, exp_res == 32'b0});
    check("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
    @(posedge clk);
    if (clr) model_sticky = 1'b0;
    else if (exp_ovf) model_sticky = 1'b1;
    #1;
    check("ovf_sticky", {31'b0, ovf_sticky}, {31'b0, model_sticky});
  endtask

  logic [5:0]  legal_ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h0D};
  logic [5:0]  alu_codes [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B};
  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                               32'h12345678};

  function automatic logic [31:0] pick_operand();
    if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
    return $urandom;
  endfunction

  initial begin
    reset = 1'b1; op = '0; funct = '0; aluop_in = '0; alucontrol_in = '0;
    a = '0; b = '0; stat_clr = 1'b0; model_sticky = 1'b0;
    #12;
    check("reset_sticky", {31'b0, ovf_sticky}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    apply(6'b100011, 6'h00, 2'b00, 6'h20, 32'd5, 32'd7, 1'b0);
    apply(6'b111111, 6'h00, 2'b00, 6'h20, 32'd0, 32'd0, 1'b0);
    apply(6'b000000, 6'h2A, 2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1, 1'b0);
    apply(6'b000000, 6'h2B, 2'b10, 6'h2B, 32'hFFFFFFFF, 32'd1, 1'b0);
    apply(6'b000100, 6'h00, 2'b01, 6'h22, 32'h12345678, 32'h12345678, 1'b0);
    apply(6'b000000, 6'h20, 2'b10, 6'h20, 32'h7FFFFFFF, 32'd1, 1'b0);
    apply(6'b000000, 6'h21, 2'b10, 6'h21, 32'h7FFFFFFF, 32'd1, 1'b0);
    apply(6'b000000, 6'h20, 2'b10, 6'h20, 32'h7FFFFFFF, 32'd1, 1'b1);
    apply(6'b000000, 6'h22, 2'b10, 6'h22, 32'h80000000, 32'd1, 1'b0);
    // Asynchronous reset mid-cycle must drop the sticky flag without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    model_sticky = 1'b0;
    check("async_reset", {31'b0, ovf_sticky}, 32'd0);
    reset = 1'b0;
    apply(6'b001101, 6'h00, 2'b11, 6'h25, 32'hF0, 32'h0F, 1'b0);

    for (int i = 0; i < 300; i++) begin
      logic [5:0] o;
      logic [5:0] c;
      o = ($urandom_range(1) == 0) ? legal_ops[$urandom_range(6)] : 6'($urandom);
      c = ($urandom_range(3) != 0) ? alu_codes[$urandom_range(9)] : 6'($urandom);
      apply(o, 6'($urandom), 2'($urandom), c, pick_operand(), pick_operand(),
            $urandom_range(7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
